branch_predictor: RTL

- Parametrised dynamic branch predictor for the 5-stage RV32 pipeline; the successor to the fixed predict-not-taken scheme, where every taken branch or jump costs a two-stage flush.
- Fetch looks up a direct-mapped BTB with 2-bit saturating counters, keyed by PC, to obtain a predicted direction and target.
- Execute reports the resolved outcome; the block updates the table and raises a mispredict with the corrected PC, which the hazard logic turns into Flush_D/Flush_E.
- The block also keeps saturating performance counters.

---
 rtl/rv_pkg.sv | 31 +++
 rtl/btb_table.sv | 89 ++++++++
 rtl/branch_predictor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32 constants and the direction-counter update helper
//               used by the dynamic branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN = 32;

    // Major opcodes of the control-transfer instructions
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    // Saturating step of a direction counter of ctr_w bits (1..3), carried in
    // a 3-bit container so a single function serves every counter width.
    function automatic logic [2:0] ctr_sat_update(input logic [2:0] ctr,
                                                  input logic       taken,
                                                  input int unsigned ctr_w);
        logic [2:0] max_v;
        max_v = 3'((1 << ctr_w) - 1);
        if (taken) begin
            return (ctr == max_v) ? ctr : ctr + 3'd1;
        end
        return (ctr == 3'd0) ? ctr : ctr - 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_table.sv
`default_nettype none
// ============================================================================
// Module      : btb_table
// Description : Direct-mapped BTB storage. Two combinational read ports
//               (fetch lookup, execute update) and one synchronous
//               write/invalidate port addressed by the execute index.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_table
    import rv_pkg::*;
#(
    parameter int XLEN    = rv_pkg::XLEN,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - 2 - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    // fetch read port
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [CTR_W-1:0] rd_ctr,
    output logic             rd_jump,
    output logic [XLEN-1:0]  rd_target,
    // execute read/write port
    input  logic [IDX_W-1:0] ex_idx,
    output logic             ex_valid,
    output logic [TAG_W-1:0] ex_tag,
    output logic [CTR_W-1:0] ex_ctr,
    input  logic             wr_en,
    input  logic             wr_tgt_en,
    input  logic             inv_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [CTR_W-1:0] wr_ctr,
    input  logic             wr_jump,
    input  logic [XLEN-1:0]  wr_target
);

    // Weakly-not-taken: just below the taken threshold
    localparam logic [CTR_W-1:0] c_ctr_wnt = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_jump;
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];

    // Zero-latency reads; a same-cycle write is not forwarded
    always_comb begin
        rd_valid  = r_valid[rd_idx];
        rd_tag    = r_tag[rd_idx];
        rd_ctr    = r_ctr[rd_idx];
        rd_jump   = r_jump[rd_idx];
        rd_target = r_target[rd_idx];
        ex_valid  = r_valid[ex_idx];
        ex_tag    = r_tag[ex_idx];
        ex_ctr    = r_ctr[ex_idx];
    end

    // Valid bits and counters: cleared to weakly-not-taken on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_ctr_wnt;
            end
        end else if (wr_en) begin
            r_valid[ex_idx] <= 1'b1;
            r_ctr[ex_idx]   <= wr_ctr;
        end else if (inv_en) begin
            r_valid[ex_idx] <= 1'b0;
        end
    end

    // Tag, kind and target payload: meaningless while invalid, so no reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            r_tag[ex_idx]  <= wr_tag;
            r_jump[ex_idx] <= wr_jump;
        end
        if (!rst && wr_tgt_en) begin
            r_target[ex_idx] <= wr_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic branch predictor for the 5-stage RV32 pipeline.
//               Fetch-side BTB lookup, execute-side resolution with
//               mispredict/redirect generation, table training and
//               saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import rv_pkg::*;
#(
    parameter int XLEN    = rv_pkg::XLEN,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   PC_F,
    output logic              PredTaken_F,
    output logic [XLEN-1:0]   PredTarget_F,
    input  logic              UpdValid_E,
    input  logic              UpdIsCti_E,
    input  logic              UpdIsJump_E,
    input  logic [XLEN-1:0]   UpdPC_E,
    input  logic              UpdTaken_E,
    input  logic [XLEN-1:0]   UpdTarget_E,
    input  logic              UpdPredTaken_E,
    input  logic [XLEN-1:0]   UpdPredTarget_E,
    output logic              Mispredict_E,
    output logic [XLEN-1:0]   RedirectPC_E,
    output logic [STAT_W-1:0] StatCti,
    output logic [STAT_W-1:0] StatMiss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    localparam logic [CTR_W-1:0] c_ctr_max = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctr_wt  = CTR_W'(1 << (CTR_W - 1));

    logic [IDX_W-1:0]  w_idx_f, w_idx_e;
    logic [TAG_W-1:0]  w_tag_f, w_tag_e;
    logic              w_rd_valid, w_rd_jump, w_ex_valid;
    logic [TAG_W-1:0]  w_rd_tag, w_ex_tag;
    logic [CTR_W-1:0]  w_rd_ctr, w_ex_ctr, w_wr_ctr;
    logic [XLEN-1:0]   w_rd_target;
    logic              w_hit_f, w_hit_e, w_upd;
    logic              w_wr_en, w_wr_tgt_en, w_inv_en;
    logic [2:0]        w_ctr_sat;
    logic [STAT_W-1:0] r_stat_cti, r_stat_miss;
    logic              w_unused_bits;

    assign w_idx_f = PC_F[IDX_W+1:2];
    assign w_tag_f = PC_F[XLEN-1:IDX_W+2];
    assign w_idx_e = UpdPC_E[IDX_W+1:2];
    assign w_tag_e = UpdPC_E[XLEN-1:IDX_W+2];

    // Instruction-aligned PC bits and the spare counter container bits
    assign w_unused_bits = ^{PC_F[1:0], UpdPC_E[1:0], w_ctr_sat};

    btb_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (w_idx_f),
        .rd_valid  (w_rd_valid),
        .rd_tag    (w_rd_tag),
        .rd_ctr    (w_rd_ctr),
        .rd_jump   (w_rd_jump),
        .rd_target (w_rd_target),
        .ex_idx    (w_idx_e),
        .ex_valid  (w_ex_valid),
        .ex_tag    (w_ex_tag),
        .ex_ctr    (w_ex_ctr),
        .wr_en     (w_wr_en),
        .wr_tgt_en (w_wr_tgt_en),
        .inv_en    (w_inv_en),
        .wr_tag    (w_tag_e),
        .wr_ctr    (w_wr_ctr),
        .wr_jump   (UpdIsJump_E),
        .wr_target (UpdTarget_E)
    );

    assign w_hit_f = w_rd_valid && (w_rd_tag == w_tag_f);
    assign w_hit_e = w_ex_valid && (w_ex_tag == w_tag_e);
    // Updates arriving during reset are dropped
    assign w_upd   = UpdValid_E && !rst;

    // Fetch prediction: jumps always redirect, branches follow the counter MSB
    always_comb begin
        PredTaken_F  = 1'b0;
        PredTarget_F = '0;
        if (!rst) begin
            PredTaken_F  = w_hit_f && (w_rd_jump || w_rd_ctr[CTR_W-1]);
            PredTarget_F = w_hit_f ? w_rd_target : PC_F + XLEN'(4);
        end
    end

    // Execute resolution: any predicted redirect on a non-CTI is a stale hit
    always_comb begin
        Mispredict_E = 1'b0;
        RedirectPC_E = '0;
        if (w_upd) begin
            if (UpdIsCti_E) begin
                Mispredict_E = (UpdTaken_E != UpdPredTaken_E) ||
                               (UpdTaken_E && (UpdTarget_E != UpdPredTarget_E));
            end else begin
                Mispredict_E = UpdPredTaken_E;
            end
            RedirectPC_E = UpdTaken_E ? UpdTarget_E : UpdPC_E + XLEN'(4);
        end
    end

    // Training: hits always train, misses allocate only when taken
    assign w_ctr_sat   = ctr_sat_update(3'(w_ex_ctr), UpdTaken_E, CTR_W);
    assign w_wr_en     = w_upd && UpdIsCti_E && (w_hit_e || UpdTaken_E);
    assign w_wr_tgt_en = w_wr_en && (UpdTaken_E || UpdIsJump_E);
    assign w_inv_en    = w_upd && !UpdIsCti_E && w_hit_e;
    assign w_wr_ctr    = UpdIsJump_E ? c_ctr_max :
                         w_hit_e     ? w_ctr_sat[CTR_W-1:0] : c_ctr_wt;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cti  <= '0;
            r_stat_miss <= '0;
        end else begin
            if (w_upd && UpdIsCti_E && (r_stat_cti != '1)) begin
                r_stat_cti <= r_stat_cti + 1'b1;
            end
            if (Mispredict_E && (r_stat_miss != '1)) begin
                r_stat_miss <= r_stat_miss + 1'b1;
            end
        end
    end

    assign StatCti  = r_stat_cti;
    assign StatMiss = r_stat_miss;

endmodule
`default_nettype wire
